key_actuator: RTL and testbench
===============================

Name: key_actuator

Overview:
- Downstream of the note-timing/sync stage; consumes its stream of planned key strikes.
- Drives one solenoid line per piano key.
- Each accepted note energises the key's solenoid for a commanded number of ticks, then enforces a minimum release gap before that key can be struck again.
- Shared tick prescaler; per-key independent channels, so chords and overlapping notes on different keys are supported.

Parameters:
- NUM_KEYS, 8, number of solenoid channels.
- KEY_W, 3, width of key index; must satisfy 2**KEY_W >= NUM_KEYS.
- DUR_W, 16, width of duration field, in ticks.
- TICK_DIV, 65000, clk cycles per tick (1 ms at 65 MHz); must be >= 2.
- MIN_GAP, 20, release ticks enforced after every press; must be >= 1.
- MAX_HOLD, 2000, hold clamp in ticks; used only with HOLD_LIMIT_EN.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- note_valid  in  1  upstream offers a note this cycle.
- note_ready  out  1  block accepts the offered note this cycle.
- note_key  in  KEY_W  key index of the offered note.
- note_dur  in  DUR_W  press duration in ticks.
- solenoid  out  NUM_KEYS  per-key drive, 1 = energised.
- busy  out  1  any channel not IDLE.
- clamp_flag  out  1  sticky: a duration was clamped (HOLD_LIMIT_EN only).

Behaviour:
- Reset is asynchronous and active-low; clk and rst_n as named above.
- Reset values, applied immediately when rst_n falls:
  - solenoid = 0
  - busy = 0
  - clamp_flag = 0
  - all channels IDLE, all counters 0, prescaler 0.
- Reset mid-press drops the solenoid at once. No pending work survives reset.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps; free-running from reset.
  - tick is a 1-cycle internal pulse on the cycle the count equals TICK_DIV-1.
- Per-channel FSM, states IDLE, PRESS, GAP; each channel has a DUR_W-bit down-counter.
- note_ready is combinational on note_key:
  - 1 if note_key >= NUM_KEYS;
  - otherwise 1 if that key's channel is IDLE, else 0.
- Handshake occurs when note_valid & note_ready. note_key and note_dur are sampled at that edge.
- On handshake, by case:
  - Key out of range: note discarded, no state change.
  - note_dur == 0: note discarded, channel stays IDLE.
  - Otherwise: channel goes to PRESS, counter := note_dur, and solenoid[key] = 1 from the next cycle (latency 1).
- PRESS: on each tick, counter decrements. When a tick arrives with counter == 1, the channel goes to GAP with counter := MIN_GAP, and solenoid goes low the next cycle.
- Press length is exactly note_dur tick pulses counted after acceptance. A tick coinciding with the handshake cycle is not counted.
- GAP: solenoid = 0. On each tick, counter decrements. When a tick arrives with counter == 1, the channel goes to IDLE and note_ready for that key rises the next cycle.
- A note offered for a busy key is held by upstream; it is never dropped. note_valid stays high and the inputs stay stable until ready.
- busy is the registered OR of (channel != IDLE) across all channels. It reflects the same cycle as the state registers.
- Only one note is accepted per cycle; channels run independently and concurrently.
- Counters never underflow; decrement happens only when the counter is >= 1.

Optional Feature:
- Macro HOLD_LIMIT_EN.
- Defined:
  - On handshake, if note_dur > MAX_HOLD, the loaded duration is MAX_HOLD.
  - clamp_flag sets on the following cycle and stays 1 until reset.
  - This protects solenoids from thermal overload.
- Undefined:
  - note_dur is loaded unmodified.
  - clamp_flag is tied 0.
  - No comparator logic is built.

Test Plan (TICK_DIV=4, MIN_GAP=2, NUM_KEYS=8, MAX_HOLD=5):
- Single note, key 3, dur 3 → solenoid[3] high the cycle after the handshake, low the cycle after the 3rd subsequent tick. note_ready for key 3 stays 0 for exactly 2 further ticks, then returns to 1. busy tracks the same window.
- Chord: keys 0, 1, 2 offered on consecutive cycles with dur 2 → all accepted with no stall. solenoid = 3'b111 overlap window present; each channel drops independently.
- Re-strike: key 5 dur 1, then key 5 dur 1 offered immediately → second note stalls (ready=0) through PRESS and GAP, and is accepted the cycle ready returns. Two distinct pulses are separated by >= 2 ticks.
- Edge inputs: key 9 dur 4, and key 2 dur 0 → both accepted with ready=1. solenoid stays 0 and busy stays 0.
- Reset during PRESS of key 4 dur 10 → solenoid[4] falls in the same cycle rst_n falls, before any clock edge. After release, all channels are IDLE and ready=1.
- HOLD_LIMIT_EN defined: key 1 dur 9 → press lasts 5 ticks and clamp_flag goes 1 and stays 1. Without the macro: press lasts 9 ticks and clamp_flag stays 0.

Source files
------------

// File: rtl/key_actuator.sv
// key_actuator: drives one solenoid per piano key from a stream of planned strikes.
// Each accepted note energises its key for note_dur ticks, then holds the key off
// for MIN_GAP ticks before it can be struck again. A single prescaler generates the
// tick shared by all channels; channels run independently, so chords are supported.
//
// Optional build macro: HOLD_LIMIT_EN clamps loaded durations to MAX_HOLD ticks and
// raises the sticky clamp_flag. When undefined, no comparator is built and
// clamp_flag is tied 0.
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   note_valid   upstream offers a note this cycle
//   note_ready   combinational: offered key is out of range or its channel is idle
//   note_key     key index of the offered note
//   note_dur     press duration in ticks (0 = discard)
//   solenoid     per-key drive, 1 = energised (registered)
//   busy         any channel not idle (registered)
//   clamp_flag   sticky: a duration was clamped (HOLD_LIMIT_EN only)
module key_actuator #(
    parameter int unsigned NUM_KEYS = 8,
    parameter int unsigned KEY_W    = 3,
    parameter int unsigned DUR_W    = 16,
    parameter int unsigned TICK_DIV = 65000,
    parameter int unsigned MIN_GAP  = 20,
    parameter int unsigned MAX_HOLD = 2000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                note_valid,
    output logic                note_ready,
    input  logic [KEY_W-1:0]    note_key,
    input  logic [DUR_W-1:0]    note_dur,
    output logic [NUM_KEYS-1:0] solenoid,
    output logic                busy,
    output logic                clamp_flag
);

    localparam int unsigned PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRESS = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    // Illegal parameter combinations elaborate this empty marker block.
    if (((2 ** KEY_W) < NUM_KEYS) || (TICK_DIV < 2) || (MIN_GAP < 1) || (MAX_HOLD < 1))
    begin : g_bad_params
    end

    logic [PS_W-1:0]                  ps_q, ps_d;
    logic                             tick_c;
    logic [NUM_KEYS-1:0][1:0]         state_q, state_d;
    logic [NUM_KEYS-1:0][DUR_W-1:0]   cnt_q, cnt_d;
    logic [NUM_KEYS-1:0]              sol_q, sol_d;
    logic                             busy_q, busy_d;
    logic                             hs_c;
    logic                             key_hit_c;
    logic [DUR_W-1:0]                 load_dur_c;

    // Free-running tick prescaler.
    always_comb begin
        tick_c = (ps_q == PS_W'(TICK_DIV - 1));
        ps_d   = tick_c ? '0 : ps_q + PS_W'(1);
    end

    // Ready decode: out-of-range keys are always accepted (and discarded).
    always_comb begin
        note_ready = 1'b1;
        key_hit_c  = 1'b0;
        for (int k = 0; k < int'(NUM_KEYS); k++) begin
            if (note_key == KEY_W'(k)) begin
                key_hit_c  = 1'b1;
                note_ready = (state_q[k] == ST_IDLE);
            end
        end
        hs_c = note_valid & note_ready;
    end

`ifdef HOLD_LIMIT_EN
    logic over_c;
    logic clamp_q, clamp_d;

    always_comb begin
        over_c     = (note_dur > DUR_W'(MAX_HOLD));
        load_dur_c = over_c ? DUR_W'(MAX_HOLD) : note_dur;
        clamp_d    = clamp_q | (hs_c & key_hit_c & over_c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) clamp_q <= 1'b0;
        else        clamp_q <= clamp_d;
    end

    assign clamp_flag = clamp_q;
`else
    assign load_dur_c = note_dur;
    assign clamp_flag = 1'b0;
`endif

    // Per-channel next state; counters only move on ticks and only while >= 1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sol_d   = '0;
        busy_d  = 1'b0;
        for (int k = 0; k < int'(NUM_KEYS); k++) begin
            case (state_q[k])
                ST_IDLE: begin
                    if (hs_c && (note_key == KEY_W'(k)) && (load_dur_c != '0)) begin
                        state_d[k] = ST_PRESS;
                        cnt_d[k]   = load_dur_c;
                    end
                end
                ST_PRESS: begin
                    if (tick_c && (cnt_q[k] != '0)) begin
                        if (cnt_q[k] == DUR_W'(1)) begin
                            state_d[k] = ST_GAP;
                            cnt_d[k]   = DUR_W'(MIN_GAP);
                        end else begin
                            cnt_d[k] = cnt_q[k] - DUR_W'(1);
                        end
                    end
                end
                ST_GAP: begin
                    if (tick_c && (cnt_q[k] != '0)) begin
                        if (cnt_q[k] == DUR_W'(1)) begin
                            state_d[k] = ST_IDLE;
                            cnt_d[k]   = '0;
                        end else begin
                            cnt_d[k] = cnt_q[k] - DUR_W'(1);
                        end
                    end
                end
                default: begin
                    state_d[k] = ST_IDLE;
                    cnt_d[k]   = '0;
                end
            endcase
            sol_d[k] = (state_d[k] == ST_PRESS);
            busy_d   = busy_d | (state_d[k] != ST_IDLE);
        end
    end

    // State, counters and registered outputs; reset drops every solenoid at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_q    <= '0;
            state_q <= '0;
            cnt_q   <= '0;
            sol_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            ps_q    <= ps_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sol_q   <= sol_d;
            busy_q  <= busy_d;
        end
    end

    assign solenoid = sol_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_key_actuator.sv
// Testbench for key_actuator: a tick-count reference model (each note owns an
// absolute tick window) checked every cycle, plus directed scenarios with
// hand-computed literal expectations.
module tb_key_actuator;

    localparam int unsigned NUM_KEYS = 8;
    localparam int unsigned KW       = 4;
    localparam int unsigned DW       = 16;
    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned MIN_GAP  = 2;
    localparam int unsigned MAX_HOLD = 5;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                note_valid = 1'b0;
    logic                note_ready;
    logic [KW-1:0]       note_key = '0;
    logic [DW-1:0]       note_dur = '0;
    logic [NUM_KEYS-1:0] solenoid;
    logic                busy;
    logic                clamp_flag;

    key_actuator #(
        .NUM_KEYS(NUM_KEYS), .KEY_W(KW), .DUR_W(DW),
        .TICK_DIV(TICK_DIV), .MIN_GAP(MIN_GAP), .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .note_valid(note_valid), .note_ready(note_ready),
        .note_key(note_key), .note_dur(note_dur),
        .solenoid(solenoid), .busy(busy), .clamp_flag(clamp_flag)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: count ticks since reset; a note accepted when tcount = T
    // presses until tick T+dur and blocks its key until tick T+dur+MIN_GAP.
    longint m_cyc;
    longint m_tcount;
    longint m_press_end [NUM_KEYS];
    longint m_gap_end   [NUM_KEYS];
    bit     m_clamp;

    function automatic bit m_ready(input int key);
        if (key >= int'(NUM_KEYS)) return 1'b1;
        return (m_tcount >= m_gap_end[key]);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc    = 0;
            m_tcount = 0;
            m_clamp  = 1'b0;
            for (int k = 0; k < int'(NUM_KEYS); k++) begin
                m_press_end[k] = 0;
                m_gap_end[k]   = 0;
            end
        end else begin
            bit     acc;
            bit     tick;
            int     key;
            longint dur;
            key  = int'(note_key);
            acc  = note_valid && m_ready(key);
            tick = ((m_cyc % TICK_DIV) == TICK_DIV - 1);
            m_cyc++;
            if (tick) m_tcount++;
            dur = longint'(note_dur);
`ifdef HOLD_LIMIT_EN
            if (acc && key < int'(NUM_KEYS) && dur > MAX_HOLD) begin
                dur     = MAX_HOLD;
                m_clamp = 1'b1;
            end
`endif
            if (acc && key < int'(NUM_KEYS) && dur > 0) begin
                m_press_end[key] = m_tcount + dur;
                m_gap_end[key]   = m_tcount + dur + MIN_GAP;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            logic [NUM_KEYS-1:0] exp_sol;
            bit                  exp_busy;
            exp_busy = 1'b0;
            for (int k = 0; k < int'(NUM_KEYS); k++) begin
                exp_sol[k] = (m_tcount < m_press_end[k]);
                if (m_tcount < m_gap_end[k]) exp_busy = 1'b1;
            end
            chk("solenoid", longint'(solenoid), longint'(exp_sol));
            chk("busy", longint'(busy), longint'(exp_busy));
            chk("clamp_flag", longint'(clamp_flag), longint'(m_clamp));
            chk("note_ready", longint'(note_ready), longint'(m_ready(int'(note_key))));
        end
    end

    task automatic do_reset();
        chk_en     = 1'b0;
        note_valid = 1'b0;
        rst_n      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
    endtask

    // Offer one note and hold it until accepted; waited = cycles stalled.
    task automatic offer(input int key, input int dur, output int waited);
        bit acc;
        acc        = 1'b0;
        waited     = 0;
        note_key   = KW'(key);
        note_dur   = DW'(dur);
        note_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            #2;
            acc = note_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            waited++;
        end
        note_valid = 1'b0;
        if (!acc) begin
            n_assert++;
            n_fail++;
            $display("FAIL offer_timeout: key %0d never accepted, got ready 0 expected 1", key);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, w2, sol_cnt, busy_cnt;
        bit saw_chord;

        // Reset state.
        do_reset();
        #1;
        chk("reset_solenoid", longint'(solenoid), 0);
        chk("reset_busy", longint'(busy), 0);
        chk("reset_clamp", longint'(clamp_flag), 0);

        // Single note key 3 dur 3, accepted at cycle 0: ticks at cycles 3,7,11 end
        // the press (11 cycles high), gap ticks 15,19 (19 cycles busy).
        do_reset();
        offer(3, 3, w);
        chk("single_wait", w, 0);
        sol_cnt  = 0;
        busy_cnt = 0;
        repeat (30) begin
            @(negedge clk);
            sol_cnt  += int'(solenoid[3]);
            busy_cnt += int'(busy);
        end
        chk("single_press_cycles", sol_cnt, 11);
        chk("single_busy_cycles", busy_cnt, 19);

        // Chord on keys 0,1,2 with no stall and a full overlap.
        do_reset();
        offer(0, 2, w);  w2 = w;
        offer(1, 2, w);  w2 += w;
        offer(2, 2, w);  w2 += w;
        chk("chord_stalls", w2, 0);
        saw_chord = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (solenoid[2:0] == 3'b111) saw_chord = 1'b1;
        end
        chk("chord_overlap", longint'(saw_chord), 1);

        // Re-strike key 5: first press ends at tick 1 (cycle 3), gap to cycle 11,
        // so the second note stalls 11 cycles and is accepted at cycle 12.
        do_reset();
        offer(5, 1, w);
        offer(5, 1, w2);
        chk("restrike_stall", w2, 11);
        repeat (25) @(negedge clk);

        // Out-of-range key and zero duration: accepted, no activity.
        do_reset();
        offer(9, 4, w);
        chk("oob_wait", w, 0);
        offer(2, 0, w);
        chk("zero_dur_wait", w, 0);
        @(negedge clk);
        chk("edge_solenoid", longint'(solenoid), 0);
        chk("edge_busy", longint'(busy), 0);

        // Reset in the middle of a press drops the solenoid asynchronously.
        do_reset();
        offer(4, 10, w);
        repeat (3) @(posedge clk);
        #3;
        chk("pre_reset_sol4", longint'(solenoid[4]), 1);
        chk_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("async_reset_sol", longint'(solenoid), 0);
        chk("async_reset_busy", longint'(busy), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        for (int k = 0; k < int'(NUM_KEYS); k++) begin
            note_key = KW'(k);
            #1;
            chk("post_reset_ready", longint'(note_ready), 1);
        end

        // Long hold, key 1 dur 9: 9 ticks (35 cycles) or clamped to 5 ticks (19).
        do_reset();
        offer(1, 9, w);
        sol_cnt = 0;
        repeat (60) begin
            @(negedge clk);
            sol_cnt += int'(solenoid[1]);
        end
`ifdef HOLD_LIMIT_EN
        chk("hold_press_cycles", sol_cnt, 19);
        chk("hold_clamp_flag", longint'(clamp_flag), 1);
`else
        chk("hold_press_cycles", sol_cnt, 35);
        chk("hold_clamp_flag", longint'(clamp_flag), 0);
`endif

        // Randomised traffic, every cycle checked against the model.
        do_reset();
        for (int n = 0; n < 300; n++) begin
            int key, dur;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            key = int'($urandom_range(0, 9));
            dur = ($urandom_range(0, 7) == 0) ? int'($urandom_range(7, 12))
                                              : int'($urandom_range(0, 6));
            offer(key, dur, w);
        end
        repeat (80) @(negedge clk);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
